// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS core front end.
//   PC_RESET    - architectural PC value after reset
//   EXC_VECTOR  - redirect target used for a misaligned fetch target
//   ifu_state_t - fetch unit control states
//   pc_sel_t    - next-PC source select used by the next-PC unit
//   word_inc    - 32-bit modulo word increment (pc + 4)
package mips_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at pc
    HOLD  = 2'd1,  // instruction presented to decode, no request
    DROP  = 2'd2   // request at old pc is stale, waiting for its ack
  } ifu_state_t;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_JUMP   = 2'd2,
    PC_SEL_JR     = 2'd3
  } pc_sel_t;

  function automatic logic [31:0] word_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// pc_reg: architectural PC register.
//   clk   - clock, rising edge
//   reset - synchronous active-high, loads PC_RESET
//   load  - load enable for d
//   d     - next PC value
//   q     - current PC
module pc_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= PC_RESET;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Owns the PC, fetches words from instruction
// memory over req/ack and presents them to decode over valid/ready. A
// redirect from the next-PC unit replaces the PC; a fetch already in flight
// when a redirect arrives is allowed to complete and its data is discarded.
//
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   redir_valid, redir_pc         - redirect request and target
//   imem_req, imem_addr           - fetch request (combinational from state)
//   imem_ack, imem_rdata          - fetch response
//   instr_valid, instr_ready      - decode handshake
//   instr, instr_pc, pc_plus4     - presented instruction, its address, +4
//   exc_adel                      - misaligned redirect pulse
//
// Build option: define IFU_ALIGN_CHECK_EN to replace misaligned redirect
// targets with EXC_VECTOR and pulse exc_adel; otherwise the low two target
// bits are forced to zero and exc_adel is constant 0.
module ifu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        exc_adel
);

  ifu_state_t  state_reg, state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_load;
  logic [31:0] tgt_reg;
  logic [31:0] redir_eff;
  logic        redir_mis;

  logic        instr_valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc_reg;
  logic [31:0] pc_plus4_reg;

`ifdef IFU_ALIGN_CHECK_EN
  logic        exc_adel_reg;

  assign redir_mis = redir_valid && (redir_pc[1:0] != 2'b00);
  assign redir_eff = (redir_pc[1:0] != 2'b00) ? EXC_VECTOR : redir_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_adel_reg <= 1'b0;
    end else begin
      exc_adel_reg <= redir_mis;
    end
  end

  assign exc_adel = exc_adel_reg;
`else
  logic unused_low_bits;

  assign redir_mis       = 1'b0;
  assign redir_eff       = {redir_pc[31:2], 2'b00};
  assign unused_low_bits = ^{redir_pc[1:0], redir_mis};
  assign exc_adel        = 1'b0;
`endif

  pc_reg u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: begin
        if (imem_ack && !redir_valid) begin
          state_next = HOLD;
        end else if (!imem_ack && redir_valid) begin
          state_next = DROP;
        end
      end
      HOLD: begin
        if (redir_valid || instr_ready) begin
          state_next = FETCH;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Output logic: request whenever not presenting an instruction. The
  // address is the PC itself, which never moves while a request is open.
  always_comb begin
    imem_req  = (state_reg != HOLD);
    imem_addr = pc;
  end

  // PC update. A redirect always beats the sequential increment; in DROP
  // the PC only moves once the stale fetch has been acknowledged.
  always_comb begin
    pc_load = 1'b0;
    pc_next = pc;
    case (state_reg)
      FETCH: begin
        if (imem_ack) begin
          pc_load = 1'b1;
          pc_next = redir_valid ? redir_eff : word_inc(pc);
        end
      end
      DROP: begin
        if (imem_ack) begin
          pc_load = 1'b1;
          pc_next = redir_valid ? redir_eff : tgt_reg;
        end
      end
      HOLD: begin
        if (redir_valid) begin
          pc_load = 1'b1;
          pc_next = redir_eff;
        end
      end
      default: begin
        pc_load = 1'b0;
        pc_next = pc;
      end
    endcase
  end

  // Decode-side registers and the pending redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_reg         <= 32'd0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= 32'd0;
      instr_pc_reg    <= PC_RESET;
      pc_plus4_reg    <= word_inc(PC_RESET);
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ack && !redir_valid) begin
            instr_valid_reg <= 1'b1;
            instr_reg       <= imem_rdata;
            instr_pc_reg    <= pc;
            pc_plus4_reg    <= word_inc(pc);
          end else if (!imem_ack && redir_valid) begin
            tgt_reg <= redir_eff;
          end
        end
        DROP: begin
          // Latest redirect wins while the stale fetch is still open
          if (!imem_ack && redir_valid) begin
            tgt_reg <= redir_eff;
          end
        end
        HOLD: begin
          if (redir_valid || instr_ready) begin
            instr_valid_reg <= 1'b0;
          end
        end
        default: begin
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign pc_plus4    = pc_plus4_reg;

endmodule
